// File: rtl/pd_axis_sched.sv
// rtl/pd_axis_sched.sv - time-multiplexes one PD engine across pitch, roll and yaw
module pd_axis_sched #(
   parameter int LAT = 3
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        vld,
   input  logic [15:0] ptch,
   input  logic [15:0] roll,
   input  logic [15:0] yaw,
   input  logic [15:0] d_ptch,
   input  logic [15:0] d_roll,
   input  logic [15:0] d_yaw,
   output logic        eng_vld,
   output logic [1:0]  eng_axis,
   output logic [15:0] eng_desired,
   output logic [15:0] eng_actual,
   input  logic [9:0]  eng_pterm,
   input  logic [11:0] eng_dterm,
   output logic [9:0]  ptch_pterm,
   output logic [9:0]  roll_pterm,
   output logic [9:0]  yaw_pterm,
   output logic [11:0] ptch_dterm,
   output logic [11:0] roll_dterm,
   output logic [11:0] yaw_dterm,
   output logic        busy,
   output logic        done,
   output logic        ovr
);

   typedef struct packed {
      logic [15:0] d_ptch;
      logic [15:0] ptch;
      logic [15:0] d_roll;
      logic [15:0] roll;
      logic [15:0] d_yaw;
      logic [15:0] yaw;
   } sample_t;

   typedef struct packed {
      logic       v;
      logic [1:0] axis;
   } tag_t;

   typedef enum logic [2:0] {
      S_IDLE, S_ISS0, S_ISS1, S_ISS2, S_DRAIN, S_DONE
   } state_t;

   state_t      state_q;
   sample_t     pend_q;
   logic        pend_vld_q;
   logic        ovr_q;
   logic        busy_q;
   logic        done_q;
   logic        eng_vld_q;
   logic [1:0]  eng_axis_q;
   logic [15:0] eng_des_q;
   logic [15:0] eng_act_q;
   // The pitch pair goes straight into the issue registers at the start
   // edge, so only roll and yaw need to be held for the later issue cycles.
   logic [15:0] snap_d_roll_q;
   logic [15:0] snap_roll_q;
   logic [15:0] snap_d_yaw_q;
   logic [15:0] snap_yaw_q;

   tag_t        tag_q [LAT];
   tag_t        tag_out;
   logic [9:0]  ptch_pterm_q, roll_pterm_q, yaw_pterm_q;
   logic [11:0] ptch_dterm_q, roll_dterm_q, yaw_dterm_q;

   sample_t     live;
   sample_t     start_src;
   logic        start;
   logic        yaw_ret;
   logic        in_flight;

   assign live      = {d_ptch, ptch, d_roll, roll, d_yaw, yaw};
   assign tag_out   = tag_q[LAT-1];
   assign yaw_ret   = tag_out.v && (tag_out.axis == 2'd2);
   assign in_flight = (state_q == S_ISS0) || (state_q == S_ISS1) ||
                      (state_q == S_ISS2) || (state_q == S_DRAIN);

   // Decide whether a new issue sequence starts this edge and where its data comes from
   always_comb begin
      start     = 1'b0;
      start_src = live;
      if ((state_q == S_IDLE) && vld) begin
         start = 1'b1;
      end else if (state_q == S_DONE) begin
         if (vld) begin
            start = 1'b1;
         end else if (pend_vld_q) begin
            start     = 1'b1;
            start_src = pend_q;
         end
      end
   end

   // Scheduler FSM: snapshot, three issue cycles, drain, done; also queues one pending request
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= S_IDLE;
         pend_q        <= '0;
         pend_vld_q    <= 1'b0;
         ovr_q         <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         eng_vld_q     <= 1'b0;
         eng_axis_q    <= 2'd0;
         eng_des_q     <= 16'd0;
         eng_act_q     <= 16'd0;
         snap_d_roll_q <= 16'd0;
         snap_roll_q   <= 16'd0;
         snap_d_yaw_q  <= 16'd0;
         snap_yaw_q    <= 16'd0;
      end else begin
         done_q <= 1'b0;
         if (start) begin
            state_q       <= S_ISS0;
            busy_q        <= 1'b1;
            eng_vld_q     <= 1'b1;
            eng_axis_q    <= 2'd0;
            eng_des_q     <= start_src.d_ptch;
            eng_act_q     <= start_src.ptch;
            snap_d_roll_q <= start_src.d_roll;
            snap_roll_q   <= start_src.roll;
            snap_d_yaw_q  <= start_src.d_yaw;
            snap_yaw_q    <= start_src.yaw;
            if (state_q == S_DONE) begin
               // A fresh vld in DONE supersedes any queued request (newest wins).
               pend_vld_q <= 1'b0;
               if (vld && pend_vld_q) begin
                  ovr_q <= 1'b1;
               end
            end
         end else begin
            case (state_q)
               S_IDLE: ;
               S_ISS0: begin
                  state_q    <= S_ISS1;
                  eng_axis_q <= 2'd1;
                  eng_des_q  <= snap_d_roll_q;
                  eng_act_q  <= snap_roll_q;
               end
               S_ISS1: begin
                  state_q    <= S_ISS2;
                  eng_axis_q <= 2'd2;
                  eng_des_q  <= snap_d_yaw_q;
                  eng_act_q  <= snap_yaw_q;
               end
               S_ISS2: begin
                  state_q   <= S_DRAIN;
                  eng_vld_q <= 1'b0;
               end
               S_DRAIN: begin
                  if (yaw_ret) begin
                     state_q <= S_DONE;
                     done_q  <= 1'b1;
                  end
               end
               S_DONE: begin
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
               end
               default: begin
                  state_q   <= S_IDLE;
                  busy_q    <= 1'b0;
                  eng_vld_q <= 1'b0;
               end
            endcase
         end
         if (vld && in_flight) begin
            pend_q     <= live;
            pend_vld_q <= 1'b1;
            if (pend_vld_q) begin
               ovr_q <= 1'b1;
            end
         end
      end
   end

   // Track each issue's axis through the engine latency and capture its result on return
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < LAT; i++) begin
            tag_q[i] <= '0;
         end
         ptch_pterm_q <= 10'd0;
         roll_pterm_q <= 10'd0;
         yaw_pterm_q  <= 10'd0;
         ptch_dterm_q <= 12'd0;
         roll_dterm_q <= 12'd0;
         yaw_dterm_q  <= 12'd0;
      end else begin
         tag_q[0] <= '{v: eng_vld_q, axis: eng_axis_q};
         for (int i = 1; i < LAT; i++) begin
            tag_q[i] <= tag_q[i-1];
         end
         if (tag_out.v) begin
            case (tag_out.axis)
               2'd0: begin
                  ptch_pterm_q <= eng_pterm;
                  ptch_dterm_q <= eng_dterm;
               end
               2'd1: begin
                  roll_pterm_q <= eng_pterm;
                  roll_dterm_q <= eng_dterm;
               end
               2'd2: begin
                  yaw_pterm_q <= eng_pterm;
                  yaw_dterm_q <= eng_dterm;
               end
               default: ;
            endcase
         end
      end
   end

   assign eng_vld     = eng_vld_q;
   assign eng_axis    = eng_axis_q;
   assign eng_desired = eng_des_q;
   assign eng_actual  = eng_act_q;
   assign ptch_pterm  = ptch_pterm_q;
   assign roll_pterm  = roll_pterm_q;
   assign yaw_pterm   = yaw_pterm_q;
   assign ptch_dterm  = ptch_dterm_q;
   assign roll_dterm  = roll_dterm_q;
   assign yaw_dterm   = yaw_dterm_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign ovr         = ovr_q;

endmodule
